// File: rtl/ysyx_22040237_ifu_pkg.sv
// Shared IFU types and constants: reset PC, PC step, FSM states,
// next-pc select codes and the jump target alignment helper.
package ysyx_22040237_ifu_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } ifu_state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_JMP  = 2'd2
    } pc_sel_e;

    // jalr targets may be odd; bit 0 is always cleared
    function automatic logic [31:0] jmp_target(
        input logic [31:0] pc
    );
        return {pc[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/ysyx_22040237_pc_reg.sv
// Architectural PC register with hold / sequential / redirect
// next-pc selection.
module ysyx_22040237_pc_reg
    import ysyx_22040237_ifu_pkg::*;
#(
    parameter logic [31:0] RST_PC = RESET_PC,
    parameter logic [31:0] STEP   = PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_sel_e     sel_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        unique case (sel_i)
            PC_INC:  pc_d = pc_q + STEP;
            PC_JMP:  pc_d = target_i;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RST_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch stage: one fetch in flight, jump redirects
// squash stale responses, ebreak halts until reset.
module ysyx_22040237_ifu
    import ysyx_22040237_ifu_pkg::*;
#(
    parameter logic [31:0] RST_PC = RESET_PC,
    parameter logic [31:0] STEP   = PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    ifu_state_e  state_q;
    logic        drop_q;
    logic [31:0] out_pc_q;
    logic [31:0] out_inst_q;
    logic [31:0] pc;
    logic        redir;
    logic        req_fire;
    logic        out_fire;
    pc_sel_e     pc_sel;

    assign redir = redirect_valid && (state_q != S_HALT);

    // a redirect overrides halt, so the request still goes out
    assign imem_req_valid = !rst && (state_q == S_REQ)
                          && (!halt || redirect_valid);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid = !rst && (state_q == S_HOLD) && !redirect_valid;
    assign out_fire  = out_valid && out_ready;
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;

    always_comb begin
        pc_sel = PC_HOLD;
        unique case (1'b1)
            redir:    pc_sel = PC_JMP;
            out_fire: pc_sel = PC_INC;
            default:  pc_sel = PC_HOLD;
        endcase
    end

    ysyx_22040237_pc_reg #(
        .RST_PC (RST_PC),
        .STEP   (STEP)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .sel_i    (pc_sel),
        .target_i (jmp_target(redirect_pc)),
        .pc_o     (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            drop_q     <= 1'b0;
            out_pc_q   <= 32'd0;
            out_inst_q <= 32'd0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (redirect_valid) begin
                        if (req_fire) begin
                            drop_q  <= 1'b1;
                            state_q <= S_WAIT;
                        end
                    end else if (halt) begin
                        state_q <= S_HALT;
                    end else if (req_fire) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        drop_q <= !imem_rsp_valid;
                        if (imem_rsp_valid) begin
                            state_q <= S_REQ;
                        end
                    end else if (imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            out_pc_q   <= pc;
                            out_inst_q <= imem_rsp_data;
                            state_q    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || out_ready) begin
                        state_q <= S_REQ;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Bench for the IFU: imem model with settable latency, scoreboard
// of expected fetch PCs checked on every IDU handshake.
module tb_ysyx_22040237_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    ysyx_22040237_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          hs_cnt = 0;
    int          fire_cnt = 0;
    int          rsp_lat = 1;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] exp_q[$];

    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // imem model and output monitor share one cycle loop
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e);
                    chk("out_inst", out_inst, mem_word(e));
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                fire_cnt++;
                last_addr = imem_req_addr;
                pend  = 1'b1;
                paddr = imem_req_addr;
                pcnt  = rsp_lat;
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (pend) begin
                if (pcnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(paddr);
                    pend = 1'b0;
                end else begin
                    pcnt--;
                end
            end
        end
    end

    task automatic wait_hs(input int tgt);
        int n;
        n = 0;
        while (hs_cnt < tgt && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hs_wait", 32'(hs_cnt), 32'(tgt));
    endtask

    task automatic wait_ov();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("ov_wait", 32'(out_valid), 32'd1);
    endtask

    task automatic deliver(input logic [31:0] pc);
        wait_ov();
        @(posedge clk);
        #1;
        exp_q.push_back(pc);
        out_ready = 1'b1;
        wait_hs(hs_cnt + 1);
    endtask

    initial begin
        int k;
        int fc0;
        int hs0;
        logic [31:0] hpc;
        logic [31:0] hinst;

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt           = 1'b0;
        out_ready      = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
        end
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_addr", imem_req_addr, 32'h8000_0000);

        // streaming fetch with immediate accept
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h8000_0004);
        exp_q.push_back(32'h8000_0008);
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            k++;
            @(negedge clk);
        end
        chk("latency", 32'(k), 32'd2);
        wait_hs(3);
        out_ready = 1'b0;

        // IDU stall in S_HOLD
        wait_ov();
        hpc   = out_pc;
        hinst = out_inst;
        chk("hold_pc", hpc, 32'h8000_000C);
        fc0 = fire_cnt;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pc", out_pc, hpc);
            chk("stall_inst", out_inst, hinst);
        end
        chk("stall_noreq", 32'(fire_cnt), 32'(fc0));
        @(posedge clk);
        #1;
        exp_q.push_back(32'h8000_000C);
        out_ready = 1'b1;
        wait_hs(hs_cnt + 1);
        out_ready = 1'b0;

        // redirect in S_WAIT, stale response two cycles later
        deliver(32'h8000_0010);
        out_ready = 1'b0;
        rsp_lat   = 3;
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0101;
        fc0 = fire_cnt;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        rsp_lat        = 1;
        k = 0;
        while (fire_cnt == fc0 && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("redir_fire", 32'(fire_cnt), 32'(fc0 + 1));
        chk("redir_addr", last_addr, 32'h8000_0100);
        deliver(32'h8000_0100);
        out_ready = 1'b0;

        // redirect in S_HOLD while IDU is ready
        wait_ov();
        @(posedge clk);
        #1;
        hs0 = hs_cnt;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0040;
        out_ready      = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        chk("hold_redir_nohs", 32'(hs_cnt), 32'(hs0));
        deliver(32'h8000_0040);
        out_ready = 1'b0;

        // imem back-pressure
        deliver(32'h8000_0044);
        out_ready      = 1'b0;
        imem_req_ready = 1'b0;
        fc0 = fire_cnt;
        repeat (4) begin
            @(negedge clk);
            chk("bp_valid", 32'(imem_req_valid), 32'd1);
            chk("bp_addr", imem_req_addr, 32'h8000_0048);
        end
        chk("bp_nofire", 32'(fire_cnt), 32'(fc0));
        @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        deliver(32'h8000_0048);

        // halt in S_REQ, sticky until reset
        halt = 1'b1;
        fc0  = fire_cnt;
        repeat (6) begin
            @(negedge clk);
            chk("halt_req", 32'(imem_req_valid), 32'd0);
            chk("halt_out", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        halt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("halt_sticky", 32'(imem_req_valid), 32'd0);
        end
        chk("halt_nofire", 32'(fire_cnt), 32'(fc0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rerst_addr", imem_req_addr, 32'h8000_0000);
        rst = 1'b0;
        exp_q.push_back(32'h8000_0000);
        out_ready = 1'b1;
        wait_hs(hs_cnt + 1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
